m_serial_alu: RTL and testbench
===============================

M_SERIAL_ALU -- requirements
Module: m_serial_alu

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand and result width in bits.
REQ-002 SHALL have parameter DIGIT_W, default 1: bits processed per calculation cycle; DATA_W SHALL be an integer multiple of DIGIT_W (N = DATA_W/DIGIT_W).
REQ-003 SHALL have port w_clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port w_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port w_in_valid  input  1  operands and opcode present.
REQ-006 SHALL have port w_in_ready  output  1  block can accept a request.
REQ-007 SHALL have port w_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, others reserved.
REQ-008 SHALL have port w_rrs  input  DATA_W  operand A.
REQ-009 SHALL have port w_rrt  input  DATA_W  operand B.
REQ-010 SHALL have port r_out_valid  output  1  result valid, registered.
REQ-011 SHALL have port w_out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port r_rslt  output  DATA_W  result, registered.
REQ-013 SHALL have port r_cout  output  1  carry out of the MSB (ADD/SUB), registered.
REQ-014 SHALL have port r_zero  output  1  high when r_rslt is all zeros, registered.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE; w_in_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, when w_in_valid=1, the block SHALL capture w_rrs, w_rrt and w_op into internal shift registers on that edge and move to CALC; input changes after capture SHALL be ignored.
REQ-017 In CALC, each edge SHALL process one DIGIT_W-bit digit, LSB digit first, shifting operands right by DIGIT_W and the result digit in at the MSB end.
REQ-018 The carry SHALL be a 1-bit register chained between digits; ADD starts with carry 0; SUB adds the bitwise-inverted operand B with an initial carry of 1.
REQ-019 AND/OR/XOR SHALL be digit-wise; r_cout SHALL be 0 for these and for reserved opcodes.
REQ-020 Reserved opcodes SHALL take the full CALC time and produce r_rslt = 0 and r_zero = 1.
REQ-021 After exactly N edges in CALC, the block SHALL enter DONE; the N-th edge after the accepting edge SHALL set r_out_valid=1 and load r_rslt, r_cout and r_zero.
REQ-022 For SUB, r_cout=1 SHALL mean no borrow (A >= B unsigned).
REQ-023 In DONE, r_out_valid and all result outputs SHALL hold stable until w_out_ready=1; on that edge the block SHALL clear r_out_valid and return to IDLE.
REQ-024 A new request SHALL NOT be accepted on the edge that completes the output handshake; the minimum request-to-request spacing SHALL be N+2 edges.
REQ-025 When DIGIT_W = DATA_W, CALC SHALL last one edge.
REQ-026 w_out_ready SHALL be ignored outside DONE.

Reset
REQ-027 While w_rst=1 on an edge, the block SHALL enter IDLE and clear r_out_valid, r_rslt, r_cout, r_zero, the carry, the digit counter and the shift registers to 0; w_in_ready SHALL be 1 after reset.
REQ-028 A reset during CALC or DONE SHALL abort the operation with no result delivered; w_rst SHALL take priority over every other event.

Configuration
REQ-029 With macro SERIAL_ALU_SUB_EN defined, opcode 001 SHALL perform SUB as in REQ-018 and REQ-022.
REQ-030 Without SERIAL_ALU_SUB_EN, opcode 001 SHALL be treated as reserved (REQ-020), and the operand-B inversion logic SHALL NOT be built.

Verification
REQ-031 DATA_W=32, DIGIT_W=1, ADD 0xFFFFFFFF + 0x00000001 -> r_out_valid rises 32 edges after accept; r_rslt=0x00000000, r_cout=1, r_zero=1.
REQ-032 SUB 0x00000005 - 0x00000007 (SUB_EN defined) -> r_rslt=0xFFFFFFFE, r_cout=0, r_zero=0; the same request without SUB_EN -> r_rslt=0, r_zero=1.
REQ-033 DIGIT_W=4, XOR 0xA5A5A5A5 ^ 0x0F0F0F0F -> r_rslt=0xAAAAAAAA, r_cout=0, r_out_valid 8 edges after accept.
REQ-034 Backpressure: hold w_out_ready=0 for 10 cycles in DONE -> outputs stable, w_in_ready=0; pulse w_out_ready -> IDLE next edge, next accept no earlier than the following edge.
REQ-035 Assert w_rst at CALC digit 10 -> next cycle IDLE, all outputs 0, w_in_ready=1; a following ADD 3+4 -> r_rslt=7.
REQ-036 Change w_rrs and w_rrt every cycle during CALC -> result matches the operands captured at accept.

Source files
------------

// File: rtl/m_serial_alu.sv
// rtl/m_serial_alu.sv - digit-serial ADD/SUB/AND/OR/XOR ALU with valid/ready handshake (SUB behind SERIAL_ALU_SUB_EN)
module m_serial_alu #(
    parameter int DATA_W  = 32,
    parameter int DIGIT_W = 1
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_in_valid,
    output logic              w_in_ready,
    input  logic [2:0]        w_op,
    input  logic [DATA_W-1:0] w_rrs,
    input  logic [DATA_W-1:0] w_rrt,
    output logic              r_out_valid,
    input  logic              w_out_ready,
    output logic [DATA_W-1:0] r_rslt,
    output logic              r_cout,
    output logic              r_zero
);

    localparam int N     = DATA_W / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   a_sr;
    logic [DATA_W-1:0]   b_sr;
    logic [DATA_W-1:0]   res_sr;
    logic [DATA_W-1:0]   res_next;
    logic [2:0]          op_q;
    logic                carry;
    logic [CNT_W-1:0]    cnt;
    logic                last_digit;

    logic [DIGIT_W-1:0]  a_d;
    logic [DIGIT_W-1:0]  b_d;
    logic [DIGIT_W-1:0]  b_add;
    logic [DIGIT_W-1:0]  r_d;
    logic [DIGIT_W:0]    sum;
    logic                is_arith;
    logic                c_nxt;

    assign last_digit = (state == S_CALC) && (cnt == CNT_W'(N - 1));
    assign a_d        = a_sr[DIGIT_W-1:0];
    assign b_d        = b_sr[DIGIT_W-1:0];

    // Operand B path: inversion for subtraction only exists when SUB is enabled
`ifdef SERIAL_ALU_SUB_EN
    assign b_add    = (op_q == OP_SUB) ? ~b_d : b_d;
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
`else
    assign b_add    = b_d;
    assign is_arith = (op_q == OP_ADD);
`endif

    // One digit of the operation, chained through the carry register
    always_comb begin
        sum = {1'b0, a_d} + {1'b0, b_add} + {{DIGIT_W{1'b0}}, carry};
        r_d = '0;
        case (op_q)
            OP_ADD: r_d = sum[DIGIT_W-1:0];
`ifdef SERIAL_ALU_SUB_EN
            OP_SUB: r_d = sum[DIGIT_W-1:0];
`endif
            OP_AND: r_d = a_d & b_d;
            OP_OR:  r_d = a_d | b_d;
            OP_XOR: r_d = a_d ^ b_d;
            default: r_d = '0;
        endcase
        c_nxt = is_arith ? sum[DIGIT_W] : 1'b0;
    end

    // Result digits enter at the MSB end so the LSB digit ends up at bit 0
    generate
        if (DIGIT_W == DATA_W) begin : g_single
            assign res_next = r_d;
        end else begin : g_multi
            assign res_next = {r_d, res_sr[DATA_W-1:DIGIT_W]};
        end
    endgenerate

    // State register
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (w_in_valid)  state_nxt = S_CALC;
            S_CALC:  if (last_digit)  state_nxt = S_DONE;
            S_DONE:  if (w_out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs derived from state
    always_comb begin
        w_in_ready = (state == S_IDLE);
    end

    // Datapath: capture on accept, shift one digit per CALC edge, load outputs on the last digit
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            a_sr        <= '0;
            b_sr        <= '0;
            res_sr      <= '0;
            op_q        <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            r_out_valid <= 1'b0;
            r_rslt      <= '0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (w_in_valid) begin
                        a_sr   <= w_rrs;
                        b_sr   <= w_rrt;
                        op_q   <= w_op;
                        res_sr <= '0;
                        cnt    <= '0;
`ifdef SERIAL_ALU_SUB_EN
                        carry  <= (w_op == OP_SUB);
`else
                        carry  <= 1'b0;
`endif
                    end
                end
                S_CALC: begin
                    a_sr   <= a_sr >> DIGIT_W;
                    b_sr   <= b_sr >> DIGIT_W;
                    res_sr <= res_next;
                    carry  <= c_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_digit) begin
                        r_out_valid <= 1'b1;
                        r_rslt      <= res_next;
                        r_cout      <= c_nxt;
                        r_zero      <= (res_next == '0);
                    end
                end
                S_DONE: begin
                    if (w_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_serial_alu.sv
// tb/tb_m_serial_alu.sv - directed table-driven bench for m_serial_alu
module tb_m_serial_alu;

    logic             clk;
    logic             rst;
    logic [2:0]       iv;
    logic [2:0]       ir;
    logic [2:0]       ov;
    logic [2:0]       co;
    logic [2:0]       zo;
    logic [2:0][31:0] rs;
    logic             ordy;
    logic [2:0]       op_i;
    logic [31:0]      a_i;
    logic [31:0]      b_i;

    int total;
    int passed;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
        logic        z;
    } vec_t;

    vec_t vecs[12];

    m_serial_alu #(.DATA_W(32), .DIGIT_W(1)) u_d1 (
        .w_clk(clk), .w_rst(rst), .w_in_valid(iv[0]), .w_in_ready(ir[0]),
        .w_op(op_i), .w_rrs(a_i), .w_rrt(b_i), .r_out_valid(ov[0]),
        .w_out_ready(ordy), .r_rslt(rs[0]), .r_cout(co[0]), .r_zero(zo[0])
    );

    m_serial_alu #(.DATA_W(32), .DIGIT_W(4)) u_d4 (
        .w_clk(clk), .w_rst(rst), .w_in_valid(iv[1]), .w_in_ready(ir[1]),
        .w_op(op_i), .w_rrs(a_i), .w_rrt(b_i), .r_out_valid(ov[1]),
        .w_out_ready(ordy), .r_rslt(rs[1]), .r_cout(co[1]), .r_zero(zo[1])
    );

    m_serial_alu #(.DATA_W(32), .DIGIT_W(32)) u_d32 (
        .w_clk(clk), .w_rst(rst), .w_in_valid(iv[2]), .w_in_ready(ir[2]),
        .w_op(op_i), .w_rrs(a_i), .w_rrt(b_i), .r_out_valid(ov[2]),
        .w_out_ready(ordy), .r_rslt(rs[2]), .r_cout(co[2]), .r_zero(zo[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int sel, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        check({tag, "_in_ready"}, 64'(ir[sel]), 64'd1);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        iv[sel] = 1'b1;
        tick();
        iv[sel] = 1'b0;
        check({tag, "_busy"}, 64'(ir[sel]), 64'd0);
    endtask

    task automatic wait_res(input int sel, input int lat, input logic [31:0] er,
                            input logic ec, input logic ez, input bit noise, input string tag);
        int k;
        k = 0;
        while (ov[sel] !== 1'b1 && k < 100) begin
            if (noise) begin
                a_i  = $urandom;
                b_i  = $urandom;
                op_i = 3'($urandom);
            end
            tick();
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(lat));
        check({tag, "_rslt"}, 64'(rs[sel]), 64'(er));
        check({tag, "_cout"}, 64'(co[sel]), 64'(ec));
        check({tag, "_zero"}, 64'(zo[sel]), 64'(ez));
    endtask

    task automatic handshake(input int sel, input string tag);
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        check({tag, "_valid_clr"}, 64'(ov[sel]), 64'd0);
        check({tag, "_idle"}, 64'(ir[sel]), 64'd1);
    endtask

    initial begin
        int bad;
        logic [31:0] snap;
        total  = 0;
        passed = 0;
        iv     = '0;
        ordy   = 1'b0;
        op_i   = '0;
        a_i    = '0;
        b_i    = '0;

        vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
        vecs[1]  = '{3'b000, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0};
        vecs[2]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
        vecs[3]  = '{3'b000, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0};
        vecs[4]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0};
        vecs[6]  = '{3'b100, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b1};
`ifdef SERIAL_ALU_SUB_EN
        vecs[7]  = '{3'b001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[8]  = '{3'b001, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0};
        vecs[9]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1};
`else
        vecs[7]  = '{3'b001, 32'h00000005, 32'h00000007, 32'h00000000, 1'b0, 1'b1};
        vecs[8]  = '{3'b001, 32'h00000007, 32'h00000005, 32'h00000000, 1'b0, 1'b1};
        vecs[9]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1};
`endif
        vecs[10] = '{3'b101, 32'hABCD0000, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
        vecs[11] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1};

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst%0d_in_ready", s), 64'(ir[s]), 64'd1);
            check($sformatf("rst%0d_valid", s), 64'(ov[s]), 64'd0);
            check($sformatf("rst%0d_rslt", s), 64'(rs[s]), 64'd0);
            check($sformatf("rst%0d_cout", s), 64'(co[s]), 64'd0);
            check($sformatf("rst%0d_zero", s), 64'(zo[s]), 64'd0);
        end

        for (int i = 0; i < 12; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            start(0, vecs[i].op, vecs[i].a, vecs[i].b, tag);
            wait_res(0, 32, vecs[i].r, vecs[i].c, vecs[i].z, 1'b0, tag);
            handshake(0, tag);
        end

        start(1, 3'b100, 32'hA5A5A5A5, 32'h0F0F0F0F, "d4_xor");
        wait_res(1, 8, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0, "d4_xor");
        handshake(1, "d4_xor");
        start(1, 3'b000, 32'hFFFFFFFF, 32'h00000001, "d4_add");
        wait_res(1, 8, 32'h00000000, 1'b1, 1'b1, 1'b0, "d4_add");
        handshake(1, "d4_add");

        start(2, 3'b000, 32'h12345678, 32'h11111111, "d32_add");
        wait_res(2, 1, 32'h23456789, 1'b0, 1'b0, 1'b0, "d32_add");
        handshake(2, "d32_add");

        start(0, 3'b000, 32'h00000100, 32'h00000023, "bp");
        wait_res(0, 32, 32'h00000123, 1'b0, 1'b0, 1'b0, "bp");
        snap = rs[0];
        op_i = 3'b000;
        a_i  = 32'd1;
        b_i  = 32'd2;
        iv[0] = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ov[0] !== 1'b1 || rs[0] !== snap || co[0] !== 1'b0 || zo[0] !== 1'b0 || ir[0] !== 1'b0)
                bad++;
        end
        check("bp_hold_stable", 64'(bad), 64'd0);
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        check("bp_release_valid", 64'(ov[0]), 64'd0);
        check("bp_no_accept_on_hs", 64'(ir[0]), 64'd1);
        tick();
        iv[0] = 1'b0;
        check("bp_accept_next", 64'(ir[0]), 64'd0);
        wait_res(0, 32, 32'h00000003, 1'b0, 1'b0, 1'b0, "bp_next");
        handshake(0, "bp_next");

        start(0, 3'b000, 32'hFFFFFFFF, 32'h00000001, "abort");
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", 64'(ov[0]), 64'd0);
        check("abort_rslt", 64'(rs[0]), 64'd0);
        check("abort_cout", 64'(co[0]), 64'd0);
        check("abort_zero", 64'(zo[0]), 64'd0);
        check("abort_in_ready", 64'(ir[0]), 64'd1);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ov[0] !== 1'b0 || ir[0] !== 1'b1) bad++;
        end
        check("abort_no_result", 64'(bad), 64'd0);
        start(0, 3'b000, 32'd3, 32'd4, "post_abort");
        wait_res(0, 32, 32'd7, 1'b0, 1'b0, 1'b0, "post_abort");
        handshake(0, "post_abort");

        start(0, 3'b000, 32'h12345678, 32'h0000FFFF, "noise");
        wait_res(0, 32, 32'h12355677, 1'b0, 1'b0, 1'b1, "noise");
        handshake(0, "noise");
        start(1, 3'b010, 32'hDEADBEEF, 32'h0FF00FF0, "noise4");
        wait_res(1, 8, 32'h0EA00EE0, 1'b0, 1'b0, 1'b1, "noise4");
        handshake(1, "noise4");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
